// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG block reader slice.
package trng_pkg;
  localparam int ADDR_W     = 6;
  localparam int BLOCK_BITS = 1 << ADDR_W;

  localparam logic [4:0] HOLD_LO  = 5'd15;
  localparam logic [4:0] HOLD_HI  = 5'd20;
  localparam logic [4:0] CNT_WRAP = 5'd21;

  typedef enum logic {IDLE, DRAIN} state_t;
endpackage

// File: rtl/trng_popcount.sv
// Combinational ones counter over a captured entropy block.
module trng_popcount #(
  parameter int BLOCK_BITS = 64
) (
  input  logic [BLOCK_BITS-1:0] bits,
  output logic [6:0]            ones
);
  always_comb begin
    ones = '0;
    for (int i = 0; i < BLOCK_BITS; i++) ones = ones + 7'(bits[i]);
  end
endmodule

// File: rtl/trng_block_reader.sv
// Captures controller-addressed entropy bits, snapshots each completed block and
// drains the snapshot as words over valid/ready with ones-count health flags.
module trng_block_reader
  import trng_pkg::*;
#(
  parameter int ADDR_W = trng_pkg::ADDR_W,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic              done,
  input  logic [4:0]        count,
  input  logic              rnd_bit,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last,
  output logic [6:0]        block_ones,
  output logic              health_fail,
  output logic              overrun,
  output logic              busy
);
  localparam int NBITS  = 1 << ADDR_W;
  localparam int NWORDS = NBITS / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t           state;
  logic [NBITS-1:0] cap_buf, shadow;
  logic [IDX_W-1:0] idx;
  logic             done_q;
  logic [6:0]       ones;

  // Controller parks the address during its hold phase; only these counts carry fresh bits.
  wire wr_en     = (count < HOLD_LO) || (count == CNT_WRAP);
  wire done_rise = done & ~done_q;
  wire at_last   = (idx == LAST_IDX);

  trng_popcount #(.BLOCK_BITS(NBITS)) u_pop (.bits(cap_buf), .ones(ones));

  always_ff @(posedge clk) begin
    if (start) begin
      state       <= IDLE;
      cap_buf     <= '0;
      shadow      <= '0;
      idx         <= '0;
      done_q      <= 1'b0;
      block_ones  <= '0;
      health_fail <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done_q <= done;
      if (wr_en) cap_buf[address] <= rnd_bit;
      case (state)
        IDLE: if (done_rise) begin
          shadow      <= cap_buf;
          block_ones  <= ones;
          health_fail <= health_fail | (ones == 7'd0) | (ones == 7'(NBITS));
          idx         <= '0;
          state       <= DRAIN;
        end
        DRAIN: begin
          // A block completing mid-drain has nowhere to go.
          if (done_rise) overrun <= 1'b1;
          if (rd_ready) begin
            if (at_last) state <= IDLE;
            else         idx   <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == DRAIN);
  assign rd_valid = busy;
  assign rd_last  = busy & at_last;
  assign rd_data  = busy ? shadow[idx*WORD_W +: WORD_W] : '0;
endmodule

// File: tb/tb_trng_block_reader.sv
// Directed self-checking bench for trng_block_reader.
module tb_trng_block_reader;
  logic       clk = 1'b0;
  logic       start, done, rnd_bit, rd_ready;
  logic [5:0] address;
  logic [4:0] count;
  logic       rd_valid, rd_last, health_fail, overrun, busy;
  logic [7:0] rd_data;
  logic [6:0] block_ones;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    logic [63:0] pat;
    logic [6:0]  ones;
    logic        hf;
  } vec_t;
  vec_t vecs[5];

  trng_block_reader #(.ADDR_W(6), .WORD_W(8)) dut (
    .clk(clk), .start(start), .address(address), .done(done), .count(count),
    .rnd_bit(rnd_bit), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .block_ones(block_ones), .health_fail(health_fail),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sweep(input logic [63:0] pat);
    count = 5'd0;
    for (int a = 0; a < 64; a++) begin
      address = 6'(a);
      rnd_bit = pat[a];
      step();
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, rd_valid, 0);
    check({tag, "_data"}, rd_data, 0);
    check({tag, "_last"}, rd_last, 0);
    check({tag, "_ones"}, block_ones, 0);
    check({tag, "_hf"}, health_fail, 0);
    check({tag, "_ovr"}, overrun, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_block(input logic [63:0] pat, input logic [6:0] ones, input logic hf);
    sweep(pat);
    pulse_done();
    check("snap_latency", rd_valid, 1);
    rd_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      check("blk_word", rd_data, pat[w*8 +: 8]);
      check("blk_last", rd_last, (w == 7));
      step();
    end
    rd_ready = 1'b0;
    check("blk_end_valid", rd_valid, 0);
    check("blk_ones", block_ones, ones);
    check("blk_hf", health_fail, hf);
  endtask

  initial begin
    logic [63:0] p;
    logic [7:0]  held;
    int          n;
    bit          stalled;

    vecs[0] = '{64'hAAAA_AAAA_AAAA_AAAA, 7'd32, 1'b0};
    vecs[1] = '{64'h0,                   7'd0,  1'b1};
    vecs[2] = '{64'hAAAA_AAAA_AAAA_AAAA, 7'd32, 1'b1};
    vecs[3] = '{64'hFFFF_0000_F0F0_0001, 7'd25, 1'b1};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b1};

    start = 1'b1; done = 1'b0; rnd_bit = 1'b0; rd_ready = 1'b0;
    address = '0; count = '0;
    step(); step();
    start = 1'b0;
    check_all_zero("reset");
    for (int i = 0; i < 4; i++) step();
    check("idle_no_done_valid", rd_valid, 0);

    foreach (vecs[i]) run_block(vecs[i].pat, vecs[i].ones, vecs[i].hf);

    // Random backpressure: order, stability and exact transfer count.
    p = 64'h8877_6655_4433_2211;
    sweep(p);
    pulse_done();
    n = 0;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 200 && busy; cyc++) begin
      if (stalled) check("stall_hold_data", rd_data, held);
      rd_ready = 1'($urandom_range(0, 1));
      held = rd_data;
      stalled = !rd_ready;
      if (rd_ready) begin
        check("rand_word", rd_data, p[n*8 +: 8]);
        check("rand_last", rd_last, (n == 7));
        n++;
      end
      step();
    end
    rd_ready = 1'b0;
    check("rand_xfers", n, 8);
    check("rand_busy_end", busy, 0);

    // Long done: one snapshot, no overrun.
    sweep(64'h0F0F_0F0F_0F0F_0F0F);
    done = 1'b1;
    for (int i = 0; i < 5; i++) step();
    done = 1'b0;
    check("long_done_ovr", overrun, 0);
    rd_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 50 && busy; cyc++) begin
      n++;
      step();
    end
    rd_ready = 1'b0;
    check("long_done_xfers", n, 8);
    check("long_done_ones", block_ones, 32);
    step(); step();
    check("long_done_no_second", busy, 0);

    // Second done rise while stalled at word 3.
    p = 64'hDEAD_BEEF_0123_4567;
    sweep(p);
    pulse_done();
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rd_ready = 1'b0;
    sweep(~p);
    pulse_done();
    check("ovr_flag", overrun, 1);
    check("ovr_word3", rd_data, p[31:24]);
    check("ovr_ones", block_ones, 36);
    rd_ready = 1'b1;
    for (int w = 3; w < 8; w++) begin
      check("ovr_word", rd_data, p[w*8 +: 8]);
      step();
    end
    rd_ready = 1'b0;
    check("ovr_busy_end", busy, 0);
    check("ovr_sticky", overrun, 1);

    // Hold window and wrap count; the done-edge write must miss the shadow.
    sweep(64'h0);
    address = 6'd5; rnd_bit = 1'b1; count = 5'd0; step();
    for (int c = 15; c <= 20; c++) begin
      count = 5'(c);
      rnd_bit = c[0];
      step();
    end
    address = 6'd6; rnd_bit = 1'b1; count = 5'd21; step();
    address = 6'd7; rnd_bit = 1'b1; count = 5'd25; step();
    address = 6'd7; count = 5'd0;
    pulse_done();
    count = 5'd16;
    check("hold_word0", rd_data, 8'h60);
    check("hold_ones", block_ones, 2);

    // Reset mid-drain at word 4.
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_valid", rd_valid, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    rd_ready = 1'b0;
    check_all_zero("mid_reset");
    step();
    check("post_reset_valid", rd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
